uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receiver.
//               Holds the receiver state encoding and the fixed frame
//               geometry (16x oversampling, mid-bit tick, 8 data bits).
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 8;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the asynchronous serial line.
//               Both stages reset to 1 so the line reads as idle (high)
//               while and right after reset.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input
//               q     - synchronised output
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8 data bits LSB first, 1 stop bit, 16x
//               oversampling driven by the receive_baud enable pulse.
//               Optional even-parity bit enabled by macro UART_RX_PARITY_EN;
//               without it parity_err is tied low.
// Ports       : clk          - system clock (rising edge)
//               rst_n        - asynchronous active-low reset
//               receive_baud - one-clk enable at 16x the bit rate
//               rxd          - serial line, asynchronous, idle high
//               clr_rdy      - consumer acknowledge, clears rdy and flags
//               rx_data      - last received byte
//               rdy          - byte available, held until cleared
//               frame_err    - stop bit of last byte sampled low
//               parity_err   - parity mismatch on last byte
//               overrun      - sticky, byte completed while rdy was set
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       receive_baud,
  input  logic       rxd,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  logic       rxd_s;
  logic       rxd_prev;
  rx_state_e  state;
  rx_state_e  state_next;
  logic [3:0] tick;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  logic       tick_clr;
  logic       shift_en;
  logic       done;
`ifdef UART_RX_PARITY_EN
  logic       par_en;
  logic       par_bit;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-pulse control strobes; nothing moves without a pulse.
  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    shift_en   = 1'b0;
    done       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    if (receive_baud) begin
      case (state)
        IDLE: begin
          // Edge, not level: a line stuck low cannot retrigger.
          if (rxd_prev && !rxd_s) begin
            state_next = START;
            tick_clr   = 1'b1;
          end
        end
        START: begin
          if (tick == 4'(MID_TICK - 1)) begin
            tick_clr   = 1'b1;
            state_next = rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick == 4'(OVERSAMPLE - 1)) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (tick == 4'(OVERSAMPLE - 1)) begin
            par_en     = 1'b1;
            state_next = STOP;
          end
`else
          state_next = IDLE;
`endif
        end
        STOP: begin
          if (tick == 4'(OVERSAMPLE - 1)) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Tick/bit counters, shift register and edge-detect history.
  // The tick counter wraps 15->0 on its own, so DATA/PARITY/STOP stay
  // mid-bit aligned after the single clear at the centre of the start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick     <= 4'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      rxd_prev <= 1'b1;
    end else if (receive_baud) begin
      rxd_prev <= rxd_s;
      tick     <= tick_clr ? 4'd0 : tick + 4'd1;
      if (tick_clr) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shift <= {rxd_s, shift[7:1]};
      end
    end
  end

  // Completion has priority over clr_rdy so a coincident byte is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      rx_data   <= shift;
      rdy       <= 1'b1;
      frame_err <= ~rxd_s;
      overrun   <= clr_rdy ? 1'b0 : (overrun | rdy);
    end else if (clr_rdy) begin
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) begin
        par_bit <= rxd_s;
      end
      if (done) begin
        parity_err <= ^{shift, par_bit};
      end else if (clr_rdy) begin
        parity_err <= 1'b0;
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx. receive_baud
//               pulses every 4 clks; each serial bit lasts 16 pulses.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       receive_baud;
  logic       rxd;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int vectors;
  int miscompares;

  uart_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .receive_baud (receive_baud),
    .rxd          (rxd),
    .clr_rdy      (clr_rdy),
    .rx_data      (rx_data),
    .rdy          (rdy),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk baud pulse every fourth clock.
  initial begin
    receive_baud = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 receive_baud = 1'b1;
      @(posedge clk);
      #1 receive_baud = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return #1 after the next clock edge at which receive_baud is high.
  task automatic pulse_edge();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk);
      if (receive_baud === 1'b1) found = 1'b1;
    end
    #1;
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL pulse_timeout: observed none expected baud pulse");
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (16) pulse_edge();
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1 clr_rdy = 1'b0;
  endtask

  // Sends one frame and returns 1 clk after the stop-sample pulse.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input logic par_bad, input logic clr_at_done,
                            input logic exp_rdy_before);
    pulse_edge();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^data) ^ par_bad);
`else
    if (par_bad) rxd = 1'b1;
`endif
    rxd = stop_bit;
    repeat (8) pulse_edge();
    check("rdy_before_stop_sample", {7'd0, rdy}, {7'd0, exp_rdy_before});
    if (clr_at_done) begin
      wait (receive_baud === 1'b1);
      clr_rdy = 1'b1;
    end
    pulse_edge();
    clr_rdy = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    rxd     = 1'b1;
    clr_rdy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_rx_data",   rx_data,              8'h00);
    check("reset_rdy",       {7'd0, rdy},          8'h00);
    check("reset_frame_err", {7'd0, frame_err},    8'h00);
    check("reset_parity",    {7'd0, parity_err},   8'h00);
    check("reset_overrun",   {7'd0, overrun},      8'h00);
    rst_n = 1'b1;
    repeat (4) pulse_edge();

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a5_rdy",       {7'd0, rdy},        8'h01);
    check("a5_data",      rx_data,            8'hA5);
    check("a5_frame_err", {7'd0, frame_err},  8'h00);
    check("a5_parity",    {7'd0, parity_err}, 8'h00);
    check("a5_overrun",   {7'd0, overrun},    8'h00);
    pulse_clr();
    check("a5_clr_rdy",   {7'd0, rdy},        8'h00);

    // False start: low for 3 pulses then high
    pulse_edge();
    rxd = 1'b0;
    repeat (3) pulse_edge();
    rxd = 1'b1;
    repeat (24) pulse_edge();
    check("fs_rdy",       {7'd0, rdy},        8'h00);
    check("fs_frame_err", {7'd0, frame_err},  8'h00);
    check("fs_overrun",   {7'd0, overrun},    8'h00);
    check("fs_data",      rx_data,            8'hA5);

    // Framing error 0x3C, line held low afterwards
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("3c_rdy",       {7'd0, rdy},        8'h01);
    check("3c_data",      rx_data,            8'h3C);
    check("3c_frame_err", {7'd0, frame_err},  8'h01);
    pulse_clr();
    check("3c_clr_ferr",  {7'd0, frame_err},  8'h00);
    repeat (200) pulse_edge();
    check("low_hold_rdy", {7'd0, rdy},        8'h00);
    check("low_hold_data", rx_data,           8'h3C);
    rxd = 1'b1;
    repeat (20) pulse_edge();

    // Overrun: 0x11 then 0x22 with no acknowledge
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("11_data",      rx_data,            8'h11);
    check("11_overrun",   {7'd0, overrun},    8'h00);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    check("22_data",      rx_data,            8'h22);
    check("22_rdy",       {7'd0, rdy},        8'h01);
    check("22_overrun",   {7'd0, overrun},    8'h01);
    pulse_clr();
    check("ovr_clr_rdy",  {7'd0, rdy},        8'h00);
    check("ovr_clr_ovr",  {7'd0, overrun},    8'h00);

    // clr_rdy coincident with completion while rdy=1
    send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b1, 1'b1);
    check("coin_data",    rx_data,            8'h44);
    check("coin_rdy",     {7'd0, rdy},        8'h01);
    check("coin_overrun", {7'd0, overrun},    8'h00);
    pulse_clr();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par0_data",    rx_data,            8'h01);
    check("par0_err",     {7'd0, parity_err}, 8'h01);
    pulse_clr();
    check("par_clr",      {7'd0, parity_err}, 8'h00);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    check("par1_err",     {7'd0, parity_err}, 8'h00);
    pulse_clr();
`endif

    // Reset during data bit 4, with a byte pending
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check("77_data",      rx_data,            8'h77);
    pulse_edge();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rxd = 1'b0;
    repeat (8) pulse_edge();
    rst_n = 1'b0;
    #1;
    check("mid_rst_data",    rx_data,            8'h00);
    check("mid_rst_rdy",     {7'd0, rdy},        8'h00);
    check("mid_rst_ferr",    {7'd0, frame_err},  8'h00);
    check("mid_rst_overrun", {7'd0, overrun},    8'h00);
    check("mid_rst_parity",  {7'd0, parity_err}, 8'h00);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) pulse_edge();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check("5a_data",      rx_data,            8'h5A);
    check("5a_rdy",       {7'd0, rdy},        8'h01);
    check("5a_frame_err", {7'd0, frame_err},  8'h00);
    check("5a_overrun",   {7'd0, overrun},    8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
